issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- In-order, single-issue dispatch controller between the issue queue and the four function units (ALU, LSU, BPU, CSR).
- Pops decoded entries from the issue queue, holds one entry in a dispatch slot, and checks register hazards against a 32-entry busy-bit scoreboard.
- Serializes CSR operations, then hands the entry to the target unit with a valid/ready handshake.
- Scoreboard bits are cleared by unit writeback ports.

Parameters:
- ISSUE_Q_WIDTH, 123, width of one issue-queue entry.
- NUM_FU, 4, number of function units; index = function code (0 ALU, 1 LSU, 2 BPU, 3 CSR).
- NUM_WB, 2, number of writeback ports that release scoreboard bits.
- RD_WIDTH, 5, register index width.
- CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  pipeline redirect; discards the held entry.
- issue_q_rok  in  1  issue queue non-empty.
- issue_q_ren  out  1  pop the issue queue this cycle.
- issue_q_rdata  in  ISSUE_Q_WIDTH  head entry, valid when issue_q_rok=1.
- disp_valid  out  NUM_FU  one-hot dispatch valid, per unit.
- disp_ready  in  NUM_FU  per-unit accept.
- disp_data  out  ISSUE_Q_WIDTH  held entry, shared by all units.
- wb_valid  in  NUM_WB  writeback strobe, per port.
- wb_rd  in  NUM_WB*RD_WIDTH  destination register released by each port.
- sb_busy  out  32  scoreboard state (debug / CSR read).
- stall_cnt  out  CNT_WIDTH  cycles with a held entry not dispatched.

Behaviour:
- Entry layout, MSB to LSB:
  - cur_pc[32], nxt_pc[32], taken[1], rd_wen[1], rd[5], rs2[5], rs1[5], imm[32]
  - oprand[4]: bit3 = use rs1, bit2 = use rs2, bit1 = use imm, bit0 = use pc
  - operator[4], function[2]
- Reset: state EMPTY, slot cleared, disp_valid=0, issue_q_ren=0, sb_busy=0, stall_cnt=0. Reset mid-operation drops the held entry and clears all busy bits; in-flight writebacks after reset are harmless.
- States:
  - EMPTY: no held entry.
  - HOLD: entry held, waiting on a hazard or unit ready.
  - DRAIN: held entry is CSR, waiting for sb_busy==0.
- issue_q_ren = issue_q_rok & ~flush & (slot empty | dispatch fires this cycle). The popped entry is latched at the next edge, so latency is 1 cycle from pop to disp_valid. Back-to-back throughput is 1 entry/cycle.
- Hazard for the held entry:
  - RAW: (oprand[3] & busy[rs1]) | (oprand[2] & busy[rs2]).
  - WAW: rd_wen & busy[rd].
  - busy[0] is always 0.
  - "Busy" uses the effective state: a bit cleared by a writeback in the same cycle counts as not busy (same-cycle bypass).
- disp_valid[function] = held & ~hazard & ~flush & (function!=CSR | effective sb_busy==0). It is combinational from registered slot and scoreboard state.
- Dispatch fires when disp_valid[f] & disp_ready[f]. Outputs must hold stable while valid & ~ready.
- Scoreboard update each cycle:
  - Clear busy[wb_rd[i]] for each wb_valid[i].
  - Then set busy[rd] if dispatch fires with rd_wen & rd!=0.
  - Set wins over a same-cycle clear of the same register.
  - A clear of x0 or of a non-busy bit is ignored.
- Transitions:
  - EMPTY→HOLD on pop (→DRAIN if function==CSR).
  - HOLD/DRAIN→EMPTY on dispatch without pop.
  - HOLD/DRAIN→HOLD/DRAIN on dispatch with pop, re-classified by the new entry.
- flush has priority over everything: slot→EMPTY, no pop, no dispatch, scoreboard untouched. Already-dispatched ops still write back.
- stall_cnt increments (saturating) each cycle with state≠EMPTY and no dispatch; it does not increment on flush cycles.
- An unsupported function code cannot occur (2-bit field, 4 units).

Decomposition:
- Shared package holds:
  - function codes ALU/LSU/BPU/CSR.
  - operator codes.
  - oprand bit positions.
  - entry field offsets/widths (this block and the instruction decoder both use them).
- One natural sub-module: issue_scoreboard (32 busy bits, NUM_WB clear ports, one set port, effective-busy lookup for three indices).

Test Plan:
- Back-to-back independent ALU ops (add x1,x2,x3; add x4,x5,x6) with all ready=1 → disp_valid[0] on consecutive cycles, sb_busy=0x00000012, stall_cnt=0.
- RAW: add x1 then sub x7,x1,x2 with no writeback → sub held, stall_cnt counts; wb_valid[0]=1, wb_rd=1 → sub dispatches in that same cycle.
- Write to x0 (addi x0,x0,5) → dispatched, sb_busy stays 0; a following op reading x0 is not stalled.
- CSR serialization: lw x3 outstanding, then csrrs x4 → held in DRAIN until the LSU writeback of x3 clears it, then disp_valid[3]=1 and busy[4] is set.
- Backpressure: disp_ready[1]=0 for 3 cycles on sw → disp_valid and disp_data stable, issue_q_ren=0, stall_cnt=3.
- flush while held (busy x5 pending) → next cycle EMPTY, disp_valid=0, busy[5] still 1. rst asserted mid-HOLD → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler and instruction decoder:
// function/operator codes, operand-select bits and the issue-queue entry layout.
package issue_scheduler_pkg;

    localparam int ISSUE_Q_WIDTH = 123;
    localparam int NUM_FU        = 4;
    localparam int NUM_WB        = 2;
    localparam int RD_WIDTH      = 5;
    localparam int CNT_WIDTH     = 32;
    localparam int NUM_REGS      = 1 << RD_WIDTH;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_BPU = 2'd2,
        FU_CSR = 2'd3
    } fu_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_LOAD  = 4'd10,
        OP_STORE = 4'd11,
        OP_BEQ   = 4'd12,
        OP_CSRRW = 4'd13,
        OP_CSRRS = 4'd14,
        OP_CSRRC = 4'd15
    } op_e;

    localparam int OPR_RS1 = 3;
    localparam int OPR_RS2 = 2;
    localparam int OPR_IMM = 1;
    localparam int OPR_PC  = 0;

    // Field LSB offsets inside a flat entry, for users that slice the raw vector.
    localparam int FUNC_LSB   = 0;
    localparam int OP_LSB     = 2;
    localparam int OPRAND_LSB = 6;
    localparam int IMM_LSB    = 10;
    localparam int RS1_LSB    = 42;
    localparam int RS2_LSB    = 47;
    localparam int RD_LSB     = 52;
    localparam int RD_WEN_BIT = 57;
    localparam int TAKEN_BIT  = 58;
    localparam int NXT_PC_LSB = 59;
    localparam int CUR_PC_LSB = 91;

    typedef struct packed {
        logic [31:0]         cur_pc;
        logic [31:0]         nxt_pc;
        logic                taken;
        logic                rd_wen;
        logic [RD_WIDTH-1:0] rd;
        logic [RD_WIDTH-1:0] rs2;
        logic [RD_WIDTH-1:0] rs1;
        logic [31:0]         imm;
        logic [3:0]          oprand;
        logic [3:0]          operator;
        logic [1:0]          func;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/issue_scheduler_if.sv
// Issue-queue, dispatch, writeback and status signals of the issue scheduler.
interface issue_scheduler_if;
    import issue_scheduler_pkg::*;

    logic                         flush;
    logic                         issue_q_rok;
    logic                         issue_q_ren;
    logic [ISSUE_Q_WIDTH-1:0]     issue_q_rdata;
    logic [NUM_FU-1:0]            disp_valid;
    logic [NUM_FU-1:0]            disp_ready;
    logic [ISSUE_Q_WIDTH-1:0]     disp_data;
    logic [NUM_WB-1:0]            wb_valid;
    logic [NUM_WB*RD_WIDTH-1:0]   wb_rd;
    logic [NUM_REGS-1:0]          sb_busy;
    logic [CNT_WIDTH-1:0]         stall_cnt;

    modport master (
        input  flush, issue_q_rok, issue_q_rdata, disp_ready, wb_valid, wb_rd,
        output issue_q_ren, disp_valid, disp_data, sb_busy, stall_cnt
    );

    modport slave (
        output flush, issue_q_rok, issue_q_rdata, disp_ready, wb_valid, wb_rd,
        input  issue_q_ren, disp_valid, disp_data, sb_busy, stall_cnt
    );

endinterface

// File: rtl/issue_scoreboard.sv
// Register busy-bit scoreboard: writeback clears, one dispatch set, and
// effective (post-clear) lookups so a same-cycle writeback unblocks a hazard.
module issue_scoreboard
    import issue_scheduler_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*RD_WIDTH-1:0] wb_rd,
    input  logic                       set_en,
    input  logic [RD_WIDTH-1:0]        set_rd,
    input  logic [RD_WIDTH-1:0]        rs1,
    input  logic [RD_WIDTH-1:0]        rs2,
    input  logic [RD_WIDTH-1:0]        rd,
    output logic                       busy_rs1,
    output logic                       busy_rs2,
    output logic                       busy_rd,
    output logic [NUM_REGS-1:0]        busy_eff,
    output logic [NUM_REGS-1:0]        busy
);

    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        clr_mask = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i]) clr_mask[wb_rd[i*RD_WIDTH +: RD_WIDTH]] = 1'b1;
        end
    end

    always_comb begin
        set_mask = '0;
        if (set_en && set_rd != '0) set_mask[set_rd] = 1'b1;
    end

    assign busy_eff = busy & ~clr_mask;
    assign busy_rs1 = busy_eff[rs1];
    assign busy_rs2 = busy_eff[rs2];
    assign busy_rd  = busy_eff[rd];

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: busy bits are flops, not RAM, and must be reset so nothing stalls on stale hazards.
        if (rst) busy <= '0;
        else     busy <= busy_eff | set_mask;
    end

endmodule

// File: rtl/issue_scheduler.sv
// In-order single-issue dispatch: one held entry, hazard check against the
// scoreboard, CSR serialization, and one-hot valid/ready hand-off to the units.
module issue_scheduler
    import issue_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    issue_scheduler_if.master  bus
);

    state_e            state;
    entry_t            slot;
    entry_t            head;
    logic              held;
    logic              hazard;
    logic              csr_ok;
    logic              fire;
    logic              pop;
    logic              busy_rs1;
    logic              busy_rs2;
    logic              busy_rd;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_FU-1:0] valid_vec;

    assign head   = entry_t'(bus.issue_q_rdata);
    assign held   = (state != ST_EMPTY);
    assign hazard = (slot.oprand[OPR_RS1] & busy_rs1)
                  | (slot.oprand[OPR_RS2] & busy_rs2)
                  | (slot.rd_wen & busy_rd);
    // CSR ops wait until every older result has written back.
    assign csr_ok = (slot.func != FU_CSR) || (busy_eff == '0);

    always_comb begin
        valid_vec = '0;
        if (held && !hazard && !bus.flush && csr_ok) valid_vec[slot.func] = 1'b1;
    end

    assign fire = |(valid_vec & bus.disp_ready);
    assign pop  = ~rst & bus.issue_q_rok & ~bus.flush & (~held | fire);

    assign bus.issue_q_ren = pop;
    assign bus.disp_valid  = valid_vec;
    assign bus.disp_data   = slot;

    issue_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (bus.wb_valid),
        .wb_rd    (bus.wb_rd),
        .set_en   (fire & slot.rd_wen),
        .set_rd   (slot.rd),
        .rs1      (slot.rs1),
        .rs2      (slot.rs2),
        .rd       (slot.rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd),
        .busy_eff (busy_eff),
        .busy     (bus.sb_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_EMPTY;
            slot          <= '0;
            bus.stall_cnt <= '0;
        end else if (bus.flush) begin
            state <= ST_EMPTY;
            slot  <= '0;
        end else begin
            if (pop) begin
                slot  <= head;
                state <= (head.func == FU_CSR) ? ST_DRAIN : ST_HOLD;
            end else if (fire) begin
                state <= ST_EMPTY;
            end
            if (held && !fire && bus.stall_cnt != {CNT_WIDTH{1'b1}})
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: back-to-back issue, RAW bypass, x0,
// CSR drain, backpressure, flush and mid-hold reset.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic        clk;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pc_ctr   = 32'h0000_1000;
    entry_t      q[$];
    entry_t      e_a, e_b, e_p, e_s, e_x0, e_r0, e_lw, e_csr, e_sw, e_x9, e_p5, e_d6, e_z, e_w;

    issue_scheduler_if ifc ();

    issue_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic entry_t mk(input logic [1:0] func, input logic [3:0] op, input logic [3:0] opr,
                                  input logic rd_wen, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm);
        entry_t e;
        e.cur_pc   = pc_ctr;
        e.nxt_pc   = pc_ctr + 32'd4;
        e.taken    = 1'b0;
        e.rd_wen   = rd_wen;
        e.rd       = rd;
        e.rs2      = rs2;
        e.rs1      = rs1;
        e.imm      = imm;
        e.oprand   = opr;
        e.operator = op;
        e.func     = func;
        pc_ctr     = pc_ctr + 32'd4;
        return e;
    endfunction

    task automatic drive_q();
        ifc.issue_q_rok   = (q.size() != 0);
        ifc.issue_q_rdata = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input entry_t e);
        q.push_back(e);
        drive_q();
    endtask

    task automatic settle();
        #1;
    endtask

    // Pop the queue model on the edge where the DUT asserted issue_q_ren.
    task automatic tick();
        logic popped;
        #1;
        popped = ifc.issue_q_ren;
        @(posedge clk);
        #1;
        if (popped && q.size() != 0) void'(q.pop_front());
        drive_q();
    endtask

    task automatic set_wb(input logic [1:0] v, input logic [4:0] rd1, input logic [4:0] rd0);
        ifc.wb_valid = v;
        ifc.wb_rd    = {rd1, rd0};
    endtask

    initial begin
        rst            = 1'b1;
        ifc.flush      = 1'b0;
        ifc.disp_ready = 4'hF;
        set_wb(2'b00, 5'd0, 5'd0);
        drive_q();
        tick();
        tick();
        settle();
        check("rst_busy",  ifc.sb_busy, 32'h0);
        check("rst_stall", ifc.stall_cnt, 32'h0);
        check("rst_valid", ifc.disp_valid, 4'h0);
        check("rst_ren",   ifc.issue_q_ren, 1'b0);
        rst = 1'b0;

        // Back-to-back independent ALU ops
        e_a = mk(FU_ALU, OP_ADD, 4'b1100, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0);
        e_b = mk(FU_ALU, OP_ADD, 4'b1100, 1'b1, 5'd4, 5'd5, 5'd6, 32'd0);
        push(e_a);
        push(e_b);
        settle();
        check("b2b_pop_empty", ifc.issue_q_ren, 1'b1);
        check("b2b_idle_valid", ifc.disp_valid, 4'h0);
        tick(); settle();
        check("b2b_a_valid", ifc.disp_valid, 4'b0001);
        check("b2b_a_data", ifc.disp_data, e_a);
        check("b2b_a_ren", ifc.issue_q_ren, 1'b1);
        tick(); settle();
        check("b2b_b_valid", ifc.disp_valid, 4'b0001);
        check("b2b_b_data", ifc.disp_data, e_b);
        check("b2b_busy_a", ifc.sb_busy, 32'h0000_0002);
        tick(); settle();
        check("b2b_empty_valid", ifc.disp_valid, 4'h0);
        check("b2b_busy", ifc.sb_busy, 32'h0000_0012);
        check("b2b_stall", ifc.stall_cnt, 32'd0);
        set_wb(2'b11, 5'd4, 5'd1);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);
        settle();
        check("wb_dual_clear", ifc.sb_busy, 32'h0);

        // RAW hazard released by a same-cycle writeback
        e_p = mk(FU_ALU, OP_ADD, 4'b1100, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0);
        e_s = mk(FU_ALU, OP_SUB, 4'b1100, 1'b1, 5'd7, 5'd1, 5'd2, 32'd0);
        push(e_p);
        push(e_s);
        tick(); settle();
        check("raw_p_valid", ifc.disp_valid, 4'b0001);
        tick(); settle();
        check("raw_s_held", ifc.disp_valid, 4'h0);
        check("raw_busy", ifc.sb_busy, 32'h0000_0002);
        tick(); settle();
        check("raw_stall1", ifc.stall_cnt, 32'd1);
        tick(); settle();
        check("raw_stall2", ifc.stall_cnt, 32'd2);
        set_wb(2'b01, 5'd0, 5'd1);
        settle();
        check("raw_bypass", ifc.disp_valid, 4'b0001);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);
        settle();
        check("raw_busy_after", ifc.sb_busy, 32'h0000_0080);
        check("raw_stall_after", ifc.stall_cnt, 32'd2);
        check("raw_empty", ifc.disp_valid, 4'h0);
        set_wb(2'b10, 5'd7, 5'd0);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);

        // Writes to x0 never mark busy; reading x0 never stalls
        e_x0 = mk(FU_ALU, OP_ADD, 4'b1010, 1'b1, 5'd0, 5'd0, 5'd0, 32'd5);
        e_r0 = mk(FU_ALU, OP_ADD, 4'b1100, 1'b1, 5'd8, 5'd0, 5'd0, 32'd0);
        push(e_x0);
        push(e_r0);
        tick(); settle();
        check("x0_disp", ifc.disp_valid, 4'b0001);
        tick(); settle();
        check("x0_busy", ifc.sb_busy, 32'h0);
        check("x0_read_disp", ifc.disp_valid, 4'b0001);
        tick(); settle();
        check("x0_busy_x8", ifc.sb_busy, 32'h0000_0100);
        set_wb(2'b01, 5'd0, 5'd8);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);

        // CSR drains until the outstanding load writes back
        e_lw  = mk(FU_LSU, OP_LOAD, 4'b1010, 1'b1, 5'd3, 5'd2, 5'd0, 32'd16);
        e_csr = mk(FU_CSR, OP_CSRRS, 4'b1000, 1'b1, 5'd4, 5'd0, 5'd0, 32'h300);
        push(e_lw);
        push(e_csr);
        tick(); settle();
        check("csr_lw_valid", ifc.disp_valid, 4'b0010);
        tick(); settle();
        check("csr_drain", ifc.disp_valid, 4'h0);
        check("csr_busy_x3", ifc.sb_busy, 32'h0000_0008);
        tick(); settle();
        check("csr_drain2", ifc.disp_valid, 4'h0);
        check("csr_stall3", ifc.stall_cnt, 32'd3);
        tick();
        set_wb(2'b10, 5'd3, 5'd0);
        settle();
        check("csr_go", ifc.disp_valid, 4'b1000);
        check("csr_data", ifc.disp_data, e_csr);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);
        settle();
        check("csr_busy_x4", ifc.sb_busy, 32'h0000_0010);
        check("csr_stall", ifc.stall_cnt, 32'd4);
        set_wb(2'b01, 5'd0, 5'd4);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);

        // Backpressure on the LSU for three cycles
        e_sw = mk(FU_LSU, OP_STORE, 4'b1110, 1'b0, 5'd0, 5'd2, 5'd3, 32'd8);
        e_x9 = mk(FU_ALU, OP_ADD, 4'b1100, 1'b1, 5'd9, 5'd5, 5'd6, 32'd0);
        push(e_sw);
        push(e_x9);
        tick();
        ifc.disp_ready = 4'b1101;
        settle();
        check("bp_valid1", ifc.disp_valid, 4'b0010);
        check("bp_data1", ifc.disp_data, e_sw);
        check("bp_no_pop", ifc.issue_q_ren, 1'b0);
        tick(); settle();
        check("bp_valid2", ifc.disp_valid, 4'b0010);
        check("bp_data2", ifc.disp_data, e_sw);
        tick(); settle();
        check("bp_valid3", ifc.disp_valid, 4'b0010);
        check("bp_data3", ifc.disp_data, e_sw);
        tick(); settle();
        check("bp_stall", ifc.stall_cnt, 32'd7);
        ifc.disp_ready = 4'hF;
        settle();
        check("bp_release_pop", ifc.issue_q_ren, 1'b1);
        tick(); settle();
        check("bp_next_data", ifc.disp_data, e_x9);
        check("bp_next_valid", ifc.disp_valid, 4'b0001);
        tick(); settle();
        check("bp_busy_x9", ifc.sb_busy, 32'h0000_0200);

        // Flush while a dependent op is held
        e_p5 = mk(FU_ALU, OP_ADD, 4'b1100, 1'b1, 5'd5, 5'd1, 5'd2, 32'd0);
        e_d6 = mk(FU_ALU, OP_ADD, 4'b1100, 1'b1, 5'd6, 5'd5, 5'd1, 32'd0);
        e_z  = mk(FU_ALU, OP_ADD, 4'b1100, 1'b1, 5'd10, 5'd9, 5'd0, 32'd0);
        push(e_p5);
        push(e_d6);
        push(e_z);
        tick();
        tick(); settle();
        check("fl_held", ifc.disp_valid, 4'h0);
        check("fl_busy_pre", ifc.sb_busy, 32'h0000_0220);
        ifc.flush = 1'b1;
        settle();
        check("fl_ren", ifc.issue_q_ren, 1'b0);
        check("fl_valid", ifc.disp_valid, 4'h0);
        tick();
        ifc.flush = 1'b0;
        settle();
        check("fl_after_valid", ifc.disp_valid, 4'h0);
        check("fl_after_busy", ifc.sb_busy, 32'h0000_0220);
        check("fl_after_stall", ifc.stall_cnt, 32'd7);
        check("fl_after_pop", ifc.issue_q_ren, 1'b1);
        tick(); settle();
        check("fl_z_held", ifc.disp_valid, 4'h0);
        tick(); settle();
        check("fl_z_stall", ifc.stall_cnt, 32'd8);

        // Reset while holding an entry
        e_w = mk(FU_ALU, OP_ADD, 4'b1100, 1'b1, 5'd11, 5'd12, 5'd13, 32'd0);
        push(e_w);
        rst = 1'b1;
        tick(); settle();
        check("mrst_busy", ifc.sb_busy, 32'h0);
        check("mrst_stall", ifc.stall_cnt, 32'd0);
        check("mrst_valid", ifc.disp_valid, 4'h0);
        check("mrst_ren", ifc.issue_q_ren, 1'b0);
        rst = 1'b0;
        settle();
        check("mrst_pop", ifc.issue_q_ren, 1'b1);
        tick(); settle();
        check("mrst_w_valid", ifc.disp_valid, 4'b0001);
        check("mrst_w_data", ifc.disp_data, e_w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
